sample_delay: RTL and testbench

Programmable integer-sample delay line for the feedback signal path, placed directly upstream of the output pipeline register (`flip_flop`). Each cycle it accepts one signed sample and returns the sample taken D+1 cycles earlier, where D is a runtime-programmable delay setting, giving a total latency of D+2 clock edges. The output is registered, muted to zero and flagged invalid after reset and after every change of the delay setting, until the delay buffer holds a complete history for the new setting.

---
 rtl/sample_delay.sv | 91 +++++++++
 tb/tb_sample_delay.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sample_delay.sv
// Programmable integer-sample delay line: data_o after edge k is data_i
// from edge k-D-1, muted and flagged invalid until the buffer refills.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   data_i          input sample, written every edge
//   delay_i         delay setting D (registered into delay_q every edge)
//   data_o          delayed sample, 0 while valid_o is low
//   valid_o         data_o carries a genuine delayed sample
module sample_delay #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [WIDTH-1:0]  data_i,
    input  logic [ADDR_W-1:0] delay_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              valid_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] delay_q, delay_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;

    logic [WIDTH-1:0]  rd_q, rd_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   fill_tgt;
    logic [ADDR_W:0]   fill_tgt_new;
    logic              chg;

    always_comb begin
        wr_ptr_d     = wr_ptr_q + 1'b1;
        delay_d      = delay_i;
        rd_addr      = wr_ptr_q - delay_q;
        chg          = (delay_i != delay_q);
        fill_tgt     = {1'b0, delay_q} + (ADDR_W+1)'(2);
        fill_tgt_new = {1'b0, delay_i} + (ADDR_W+1)'(2);

        // D = 0 reads the slot being written this edge: forward data_i.
        if (delay_q == '0) begin
            rd_d = data_i;
        end else begin
            rd_d = mem[rd_addr];
        end

        if (chg) begin
            fill_d = '0;
        end else if (fill_q < fill_tgt) begin
            fill_d = fill_q + 1'b1;
        end else begin
            fill_d = fill_q;
        end

        // Registered outputs reflect the fill state after this edge.
        valid_d = (fill_d == fill_tgt_new);
        data_d  = valid_d ? rd_q : '0;
    end

    // Buffer and its read register carry no reset (block-RAM style).
    always_ff @(posedge clk_i) begin
        mem[wr_ptr_q] <= data_i;
        rd_q          <= rd_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            delay_q  <= '0;
            fill_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            delay_q  <= delay_d;
            fill_q   <= fill_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_sample_delay.sv
// Self-checking bench for sample_delay: directed scenarios plus a random
// stream, compared against a history-array reference model.
module tb_sample_delay;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] data_i = '0;
    logic [9:0]  delay_i = '0;
    logic [15:0] data_o;
    logic        valid_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: every sample ever applied, edge count,
    // edge of last delay change (or reset), and the last applied delay.
    logic [15:0] hist[$];
    int edge_n   = 0;
    int last_chg = 0;
    int prev_d   = 0;

    sample_delay #(.WIDTH(16), .ADDR_W(10)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (data_i),
        .delay_i (delay_i),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s edge=%0d observed=%h expected=%h",
                   tag, edge_n, obs, exp);
        end
    endtask

    // Apply one sample with delay d, clock it, and compare outputs.
    task automatic step(input string tag, input logic [15:0] din,
                        input int d);
        logic        exp_v;
        logic [15:0] exp_d;
        data_i  = din;
        delay_i = 10'(d);
        @(posedge clk_i);
        edge_n++;
        hist.push_back(din);
        if (d != prev_d) last_chg = edge_n;
        prev_d = d;
        // Valid once the setting has been stable for d+2 edges after the
        // edge that saw it change; then output is the sample d+1 edges ago.
        exp_v = ((edge_n - last_chg) >= d + 2);
        exp_d = exp_v ? hist[edge_n - d - 2] : 16'h0000;
        #1;
        chk({tag, "_valid"}, {15'd0, valid_o}, {15'd0, exp_v});
        chk({tag, "_data"}, data_o, exp_d);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_ni = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, {15'd0, valid_o}, 16'h0000);
        chk({tag, "_rst_data"}, data_o, 16'h0000);
        @(negedge clk_i);
        rst_ni   = 1'b1;
        last_chg = edge_n;
        prev_d   = 0;
    endtask

    initial begin
        int d;
        logic [15:0] r;

        // Reset state before any edge
        #1;
        chk("reset_valid", {15'd0, valid_o}, 16'h0000);
        chk("reset_data", data_o, 16'h0000);
        #20;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // D=0 ramp: latency 2 edges
        for (int i = 0; i < 20; i++) step("d0_ramp", 16'(i), 0);

        // D=5 impulse of 0x7FFF in a zero stream
        for (int i = 0; i < 30; i++)
            step("d5_imp", (i == 10) ? 16'h7FFF : 16'h0000, 5);

        // D=1023 ramp across several pointer wraps
        for (int i = 0; i < 3100; i++) step("d1023", 16'(i + 100), 1023);

        // Mid-stream change 10 -> 3 -> 200
        for (int i = 0; i < 30; i++) step("d10", 16'(i + 5000), 10);
        for (int i = 0; i < 20; i++) step("d3", 16'(i + 6000), 3);
        for (int i = 0; i < 230; i++) step("d200", 16'(i + 7000), 200);

        // Asynchronous reset while running with D=20
        for (int i = 0; i < 40; i++) step("d20", 16'(i + 9000), 20);
        async_reset("d20");
        for (int i = 0; i < 40; i++) step("d20_refill", 16'(i + 9500), 20);

        // Rapid successive changes restart the fill each time
        step("rapid", 16'h1111, 4);
        step("rapid", 16'h2222, 7);
        step("rapid", 16'h3333, 2);
        for (int i = 0; i < 10; i++) step("rapid", 16'(i + 300), 2);

        // Random signed stream with occasional random delay changes
        d = 17;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) d = $urandom_range(0, 60);
            r = 16'($urandom);
            step("random", r, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
